// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmit/receive path.
//   state_t       : keyer FSM state encoding
//   *_UNITS       : element and gap lengths in Morse time units
//   MAX_LEN       : longest character, in elements
//   cnt_width()   : counter width able to hold 0..n-1 (at least 1 bit)
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_WORD
  } state_t;

  localparam logic [2:0] DIT_UNITS      = 3'd1;
  localparam logic [2:0] DAH_UNITS      = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;
  localparam logic [2:0] MAX_LEN        = 3'd5;

  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/morse_keyer_if.sv
// Character handshake between the processor output registers and the keyer.
//   sym_valid : character available (master -> slave)
//   sym_ready : keyer idle, able to accept (slave -> master)
//   sym_bits  : elements MSB first, 1=dah 0=dit
//   sym_len   : element count 1..5, 0 = word space, 6..7 clamp to 5
interface morse_keyer_if;
  logic       sym_valid;
  logic       sym_ready;
  logic [4:0] sym_bits;
  logic [2:0] sym_len;

  modport master (
    output sym_valid,
    output sym_bits,
    output sym_len,
    input  sym_ready
  );

  modport slave (
    input  sym_valid,
    input  sym_bits,
    input  sym_len,
    output sym_ready
  );
endinterface

// File: rtl/morse_unit_timer.sv
// Morse unit timer: counts clock cycles into time units and pulses done
// on the last cycle of a span of 'units' time units.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the span (both counters to 0)
//   units      : span length in units, 1..7
//   done       : one-cycle pulse on the final cycle of the span
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 1350000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [2:0] units,
  output logic       done
);

  localparam int unsigned CW = cnt_width(UNIT_CYCLES);

  logic [CW-1:0] cyc_cnt;
  logic [2:0]    unit_cnt;
  logic          tick;

  always_comb begin
    tick = (cyc_cnt == CW'(UNIT_CYCLES - 1));
    done = tick && (unit_cnt == (units - 3'd1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt  <= '0;
      unit_cnt <= '0;
    end else if (clear) begin
      cyc_cnt  <= '0;
      unit_cnt <= '0;
    end else if (tick) begin
      cyc_cnt  <= '0;
      unit_cnt <= (unit_cnt == 3'd6) ? '0 : unit_cnt + 3'd1;
    end else begin
      cyc_cnt <= cyc_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts one encoded character per handshake and produces
// timed key-down keying plus a gated square-wave tone.
//   clk, reset : clock, asynchronous active-high reset
//   sym        : character handshake (slave side)
//   tone_en    : key-down (mark) level
//   tone_out   : square wave, low whenever tone_en is low
//   busy       : character or word space in progress
//   char_done  : one-cycle pulse on return to idle
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 1350000,
  parameter int unsigned TONE_HALF   = 13500
) (
  input  logic          clk,
  input  logic          reset,
  morse_keyer_if.slave  sym,
  output logic          tone_en,
  output logic          tone_out,
  output logic          busy,
  output logic          char_done
);

  localparam int unsigned DW = cnt_width(TONE_HALF);

  state_t        state, state_n;
  logic [2:0]    idx, idx_n;
  logic [2:0]    len_q, len_n;
  logic [4:0]    bits_q, bits_n;
  logic [2:0]    target;
  logic          timer_clear;
  logic          timer_done;
  logic          char_done_n;
  logic          tone_en_n;
  logic [2:0]    len_clamped;
  logic          last_elem;
  logic [DW-1:0] div;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .units (target),
    .done  (timer_done)
  );

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    len_n       = len_q;
    bits_n      = bits_q;
    char_done_n = 1'b0;
    target      = DIT_UNITS;
    len_clamped = (sym.sym_len > MAX_LEN) ? MAX_LEN : sym.sym_len;
    last_elem   = (idx == (len_q - 3'd1));

    unique case (state)
      ST_IDLE: begin
        // sym_ready is high exactly while in IDLE, so valid alone accepts.
        if (sym.sym_valid) begin
          len_n   = len_clamped;
          bits_n  = sym.sym_bits;
          idx_n   = '0;
          state_n = (len_clamped == '0) ? ST_WORD : ST_MARK;
        end
      end
      ST_MARK: begin
        // Current element always sits in bits_q[4]; shifted per element.
        target = bits_q[4] ? DAH_UNITS : DIT_UNITS;
        if (timer_done) state_n = ST_GAP;
      end
      ST_GAP: begin
        target = last_elem ? CHAR_GAP_UNITS : ELEM_GAP_UNITS;
        if (timer_done) begin
          if (last_elem) begin
            state_n     = ST_IDLE;
            char_done_n = 1'b1;
          end else begin
            state_n = ST_MARK;
            idx_n   = idx + 3'd1;
            bits_n  = {bits_q[3:0], 1'b0};
          end
        end
      end
      ST_WORD: begin
        target = WORD_GAP_UNITS;
        if (timer_done) begin
          state_n     = ST_IDLE;
          char_done_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Restart timing on every state change so element lengths never drift.
    timer_clear = (state_n != state) || (state == ST_IDLE);
    tone_en_n   = (state_n == ST_MARK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      len_q         <= '0;
      bits_q        <= '0;
      sym.sym_ready <= 1'b1;
      busy          <= 1'b0;
      tone_en       <= 1'b0;
      char_done     <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      len_q         <= len_n;
      bits_q        <= bits_n;
      sym.sym_ready <= (state_n == ST_IDLE);
      busy          <= (state_n != ST_IDLE);
      tone_en       <= tone_en_n;
      char_done     <= char_done_n;
    end
  end

  // Divider held clear outside marks and on the first mark cycle, so each
  // mark begins with the same low phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= '0;
      tone_out <= 1'b0;
    end else if (!tone_en_n || !tone_en) begin
      div      <= '0;
      tone_out <= 1'b0;
    end else if (div == DW'(TONE_HALF - 1)) begin
      div      <= '0;
      tone_out <= ~tone_out;
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Directed self-checking bench for morse_keyer with UNIT_CYCLES=4, TONE_HALF=2.
// Observed vector per cycle: {sym_ready, busy, tone_en, tone_out, char_done},
// sampled on the falling edge; cycle k is the interval after accept edge E0+k.
module tb_morse_keyer;

  localparam int unsigned UC = 4;
  localparam int unsigned TH = 2;

  logic clk = 1'b0;
  logic reset;
  logic tone_en, tone_out, busy, char_done;

  morse_keyer_if sym_if ();

  morse_keyer #(
    .UNIT_CYCLES(UC),
    .TONE_HALF  (TH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sym       (sym_if.slave),
    .tone_en   (tone_en),
    .tone_out  (tone_out),
    .busy      (busy),
    .char_done (char_done)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Present a character for exactly one rising edge (E0); returns at the
  // falling edge of cycle 0.
  task automatic start_char(input logic [4:0] bits, input logic [2:0] len);
    sym_if.sym_bits  = bits;
    sym_if.sym_len   = len;
    sym_if.sym_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sym_if.sym_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    reset = 1'b1;
    sym_if.sym_valid = 1'b0;
    sym_if.sym_bits  = '0;
    sym_if.sym_len   = '0;
    repeat (2) @(negedge clk);
    obs = {sym_if.sym_ready, busy, tone_en, tone_out, char_done};
    n_total++;
    if (obs !== 5'b10000)
      $display("FAIL reset_held got %b expected %b", obs, 5'b10000);
    else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    obs = {sym_if.sym_ready, busy, tone_en, tone_out, char_done};
    n_total++;
    if (obs !== 5'b10000)
      $display("FAIL reset_released got %b expected %b", obs, 5'b10000);
    else n_pass++;
  endtask

  // 'A' = dit dah: marks [0,4) and [8,20), ready at 32.
  task automatic test_char_a();
    logic [4:0] obs, expv;
    logic mark, rdy, tone;
    int p;
    start_char(5'b01000, 3'd2);
    for (int k = 0; k <= 32; k++) begin
      mark = (k < 4) || (k >= 8 && k < 20);
      p    = (k < 4) ? k : k - 8;
      tone = mark && (((p >> 1) & 1) == 1);
      rdy  = (k == 32);
      expv = {rdy, ~rdy, mark, tone, (k == 32)};
      obs  = {sym_if.sym_ready, busy, tone_en, tone_out, char_done};
      n_total++;
      if (obs !== expv)
        $display("FAIL char_a cycle %0d got %b expected %b", k, obs, expv);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_word_space();
    logic [4:0] obs, expv;
    logic rdy;
    start_char(5'b10101, 3'd0);
    for (int k = 0; k <= 28; k++) begin
      rdy  = (k == 28);
      expv = {rdy, ~rdy, 1'b0, 1'b0, (k == 28)};
      obs  = {sym_if.sym_ready, busy, tone_en, tone_out, char_done};
      n_total++;
      if (obs !== expv)
        $display("FAIL word_space cycle %0d got %b expected %b", k, obs, expv);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  // len=7 clamps to 5 dahs: 12-cycle marks every 16 cycles, ready at 88.
  task automatic test_clamp();
    logic [4:0] obs, expv;
    logic mark, rdy, tone;
    int s;
    start_char(5'b11111, 3'd7);
    for (int k = 0; k <= 88; k++) begin
      s    = k % 16;
      mark = (k < 80) && (s < 12);
      tone = mark && (((s >> 1) & 1) == 1);
      rdy  = (k == 88);
      expv = {rdy, ~rdy, mark, tone, (k == 88)};
      obs  = {sym_if.sym_ready, busy, tone_en, tone_out, char_done};
      n_total++;
      if (obs !== expv)
        $display("FAIL clamp cycle %0d got %b expected %b", k, obs, expv);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  // Valid held high with 'E': first ready at 16, re-accept at edge 17,
  // second ready at 33; valid while busy must not disturb timing.
  task automatic test_back_to_back();
    logic [4:0] obs, expv;
    logic mark, rdy, tone;
    int p;
    sym_if.sym_bits  = 5'b00000;
    sym_if.sym_len   = 3'd1;
    sym_if.sym_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= 34; k++) begin
      mark = (k < 4) || (k >= 17 && k < 21);
      p    = (k < 4) ? k : k - 17;
      tone = mark && (((p >> 1) & 1) == 1);
      rdy  = (k == 16) || (k >= 33);
      expv = {rdy, ~rdy, mark, tone, (k == 16) || (k == 33)};
      obs  = {sym_if.sym_ready, busy, tone_en, tone_out, char_done};
      n_total++;
      if (obs !== expv)
        $display("FAIL back_to_back cycle %0d got %b expected %b", k, obs, expv);
      else n_pass++;
      if (k == 17) sym_if.sym_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  // Reset at E0+10 of 'T' (dah, tone high at that point), then a fresh 'E'.
  task automatic test_reset_mid_dah();
    logic [4:0] obs, expv;
    logic mark, rdy, tone;
    start_char(5'b10000, 3'd1);
    for (int k = 0; k <= 10; k++) begin
      tone = (((k >> 1) & 1) == 1);
      expv = {1'b0, 1'b1, 1'b1, tone, 1'b0};
      obs  = {sym_if.sym_ready, busy, tone_en, tone_out, char_done};
      n_total++;
      if (obs !== expv)
        $display("FAIL dah_before_reset cycle %0d got %b expected %b", k, obs, expv);
      else n_pass++;
      if (k < 10) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    obs = {sym_if.sym_ready, busy, tone_en, tone_out, char_done};
    n_total++;
    if (obs !== 5'b10000)
      $display("FAIL async_abort got %b expected %b", obs, 5'b10000);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      obs = {sym_if.sym_ready, busy, tone_en, tone_out, char_done};
      n_total++;
      if (obs !== 5'b10000)
        $display("FAIL idle_after_abort cycle %0d got %b expected %b", k, obs, 5'b10000);
      else n_pass++;
    end
    start_char(5'b00000, 3'd1);
    for (int k = 0; k <= 17; k++) begin
      mark = (k < 4);
      tone = mark && (((k >> 1) & 1) == 1);
      rdy  = (k >= 16);
      expv = {rdy, ~rdy, mark, tone, (k == 16)};
      obs  = {sym_if.sym_ready, busy, tone_en, tone_out, char_done};
      n_total++;
      if (obs !== expv)
        $display("FAIL e_after_reset cycle %0d got %b expected %b", k, obs, expv);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_char_a();
    test_word_space();
    test_clamp();
    test_back_to_back();
    test_reset_mid_dah();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Transmit side of the Morse path: takes one encoded Morse character per handshake.
- Produces the timed on/off keying (dits, dahs, element, character and word gaps) plus a gated square-wave tone.
- Sits between the processor output registers and the audio codec tone input and the board LEDs.
- Complements the parallel Morse entry path, which goes from switches to the processor.

Parameters:
- UNIT_CYCLES, 1350000, clock cycles per Morse time unit (50 ms at 27 MHz); minimum 2.
- TONE_HALF, 13500, clock cycles per half-period of tone_out (1 kHz at 27 MHz); minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sym_valid  in  1  character available
- sym_ready  out  1  keyer idle, able to accept
- sym_bits  in  5  elements, MSB first; 1=dah, 0=dit; element i = sym_bits[4-i]
- sym_len  in  3  element count 1..5; 0 = word space; 6..7 clamped to 5
- tone_en  out  1  key-down (mark) level
- tone_out  out  1  square wave, gated by tone_en
- busy  out  1  character or space in progress (= ~sym_ready)
- char_done  out  1  one-cycle pulse when a character or word space completes

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high.
  - Outputs during and after reset: sym_ready=1, busy=0, tone_en=0, tone_out=0, char_done=0.
  - State resets to IDLE; all counters reset to 0.
- All outputs are registered.
- Accept occurs on the rising edge where sym_valid && sym_ready.
  - sym_bits and the clamped length are captured.
  - sym_ready=0 from the following cycle.
  - sym_valid while busy is ignored; no queueing.
- Unit lengths: dit mark 1 unit, dah mark 3 units, gap between elements 1 unit, gap after the last element 3 units, word space 7 units.
- FSM states:
  - IDLE: sym_ready=1. On accept with len>0, go to MARK with element index 0. On accept with len==0, go to WORD.
  - MARK: tone_en=1 for exactly units*UNIT_CYCLES cycles; the first tone_en=1 cycle is the cycle after the accept edge. Then go to GAP.
  - GAP: tone_en=0. If index < len-1, hold for 1 unit, increment index, go to MARK. Otherwise hold for 3 units and go to IDLE.
  - WORD: tone_en=0 for 7 units, then go to IDLE.
- Return to IDLE: the same edge sets sym_ready=1 and char_done=1 for exactly one cycle.
  - A new accept is possible on the next edge, so back-to-back characters have no extra idle cycle.
- Cycle count from the accept edge to the sym_ready rise:
  - Character: UNIT_CYCLES*(sum of mark units + (len-1) + 3).
  - Word space: 7*UNIT_CYCLES.
- Counters:
  - Unit counter runs 0..UNIT_CYCLES-1 and produces a one-cycle unit tick.
  - Units counter is 3 bits, 0..6.
  - Both clear on every state change, so no drift occurs between elements.
- Tone:
  - While tone_en=1, tone_out toggles every TONE_HALF cycles, starting low.
  - When tone_en=0, tone_out=0 and the divider is cleared.
  - Every mark therefore starts with an identical phase.
- Reset mid-character: the mark is aborted immediately (tone_en and tone_out go 0 asynchronously) and the keyer returns to IDLE. No char_done is issued.

Decomposition:
- Package morse_pkg holds:
  - FSM state encoding (IDLE, MARK, GAP, WORD).
  - Constants DIT_UNITS=1, DAH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7, MAX_LEN=5.
  - Counter-width function.
- Sub-module morse_unit_timer:
  - Parameterised by UNIT_CYCLES.
  - Inputs: clear and a units target. Output: done pulse.
  - Reused later by the receive-side Morse decoder.
- The tone divider stays inline.

Test Plan (UNIT_CYCLES=4, TONE_HALF=2):
- 'A': sym_len=2, sym_bits=01000, accept at edge E0 -> tone_en high E0+0..E0+4, low until E0+8, high until E0+20, sym_ready and char_done at E0+32.
- Word space: sym_len=0 -> tone_en stays 0, sym_ready returns at E0+28 with a one-cycle char_done.
- Clamp: sym_len=7, sym_bits=11111 -> exactly five 12-cycle marks separated by 4-cycle gaps, ready at E0+88.
- Back-to-back: sym_valid held high with 'E' (len=1, bits 00000) -> first char ready at E0+16, second accepted on the next edge, and valid pulses seen while busy are ignored.
- Tone: during any mark tone_out = 0,0,1,1,0,0,1,1...; tone_out=0 in every gap.
- Reset mid-dah: reset pulse at E0+10 of 'T' (len=1, bits 10000) -> tone_en=0 and tone_out=0 immediately, sym_ready=1, no char_done, and a fresh 'E' then keys correctly.
